// File: rtl/eth_rx_key_extract_pkg.sv
// Shared constants, FSM encoding and flag layout for the RX flow-key extractor.
package key_extract_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  PROTO_TCP      = 8'd6;
    localparam logic [7:0]  PROTO_UDP      = 8'd17;

    localparam int unsigned FLAG_LOOKUP   = 0;
    localparam int unsigned FLAG_TCP      = 1;
    localparam int unsigned FLAG_PORT_LSB = 2;
    localparam int unsigned FLAG_PORT_MSB = 3;

    typedef enum logic [1:0] {
        S_B0,
        S_HDR,
        S_TAIL,
        S_SKIP
    } kx_state_t;

    // Byte n of a 64-bit beat, byte 0 in the low lane.
    function automatic logic [7:0] beat_byte(input logic [63:0] data, input int unsigned n);
        return data[8*n +: 8];
    endfunction

endpackage

// File: rtl/eth_rx_key_extract_if.sv
// MAC RX stream (no tready) and lookup-engine key handshake interfaces.
interface axis_rx_if;
    logic        s_axis_rx_tvalid;
    logic [63:0] s_axis_rx_tdata;
    logic [7:0]  s_axis_rx_tkeep;
    logic        s_axis_rx_tlast;
    logic        s_axis_rx_tuser;

    modport master (output s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tkeep,
                           s_axis_rx_tlast, s_axis_rx_tuser);
    modport slave  (input  s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tkeep,
                           s_axis_rx_tlast, s_axis_rx_tuser);
endinterface

interface key_lookup_if #(
    parameter int KEY_SIZE = 96
);
    logic [KEY_SIZE-1:0] in_key;
    logic [3:0]          in_flag;
    logic                in_valid;
    logic                in_ready;

    modport master (output in_key, in_flag, in_valid, input  in_ready);
    modport slave  (input  in_key, in_flag, in_valid, output in_ready);
endinterface

// File: rtl/eth_rx_key_extract_key_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is zero while empty.
module key_fifo #(
    parameter int WIDTH = 100,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             rd_ok;
    logic             wr_ok;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign rd_ok = rd_en && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign wr_ok = wr_en && (!full || rd_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/eth_rx_key_extract.sv
// Ethernet/IPv4/TCP-UDP header parser building a 96-bit flow key into a FWFT queue.
// Optional KEY_EXTRACT_STATS_EN adds pkt_cnt/key_cnt outputs.
module eth_rx_key_extract
    import key_extract_pkg::*;
#(
    parameter int         KEY_SIZE   = 96,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] PORT_ID    = 2'd0
) (
    input  logic         clk156,
    input  logic         eth_rst,
    axis_rx_if.slave     rx,
    key_lookup_if.master lkp,
    output logic [15:0]  drop_cnt
`ifdef KEY_EXTRACT_STATS_EN
    ,
    output logic [31:0]  pkt_cnt,
    output logic [31:0]  key_cnt
`endif
);

    kx_state_t   state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic        is_tcp_q, is_tcp_d;
    logic [31:0] ip_src_q, ip_src_d;
    logic [31:0] ip_dst_q, ip_dst_d;
    logic [15:0] sport_q, sport_d;
    logic [15:0] dport_q, dport_d;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  push_flag;
    logic [KEY_SIZE+3:0] fifo_rd_data;
    logic [63:0] d;
    logic        beat_last;

    assign d         = rx.s_axis_rx_tdata;
    assign beat_last = rx.s_axis_rx_tvalid && rx.s_axis_rx_tlast;

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            state_q  <= S_B0;
            beat_q   <= '0;
            is_tcp_q <= 1'b0;
            ip_src_q <= '0;
            ip_dst_q <= '0;
            sport_q  <= '0;
            dport_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            is_tcp_q <= is_tcp_d;
            ip_src_q <= ip_src_d;
            ip_dst_q <= ip_dst_d;
            sport_q  <= sport_d;
            dport_q  <= dport_d;
        end
    end

    // Fields use their next-state values so a frame ending on beat 4 commits the fresh capture.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        is_tcp_d = is_tcp_q;
        ip_src_d = ip_src_q;
        ip_dst_d = ip_dst_q;
        sport_d  = sport_q;
        dport_d  = dport_q;
        push     = 1'b0;
        if (rx.s_axis_rx_tvalid) begin
            case (state_q)
                S_B0: begin
                    state_d = S_HDR;
                    beat_d  = 3'd1;
                end
                S_HDR: begin
                    beat_d = beat_q + 3'd1;
                    case (beat_q)
                        3'd1: begin
                            if ({beat_byte(d, 4), beat_byte(d, 5)} != ETHERTYPE_IPV4 ||
                                beat_byte(d, 6) != IPV4_VER_IHL)
                                state_d = S_SKIP;
                        end
                        3'd2: begin
                            if (beat_byte(d, 7) != PROTO_TCP && beat_byte(d, 7) != PROTO_UDP)
                                state_d = S_SKIP;
                            is_tcp_d = (beat_byte(d, 7) == PROTO_TCP);
                        end
                        3'd3: begin
                            ip_src_d = {beat_byte(d, 2), beat_byte(d, 3),
                                        beat_byte(d, 4), beat_byte(d, 5)};
                            ip_dst_d[31:16] = {beat_byte(d, 6), beat_byte(d, 7)};
                        end
                        default: begin
                            ip_dst_d[15:0] = {beat_byte(d, 0), beat_byte(d, 1)};
                            sport_d        = {beat_byte(d, 2), beat_byte(d, 3)};
                            dport_d        = {beat_byte(d, 4), beat_byte(d, 5)};
                            state_d        = S_TAIL;
                            push           = rx.s_axis_rx_tlast && rx.s_axis_rx_tuser;
                        end
                    endcase
                end
                S_TAIL: push = rx.s_axis_rx_tlast && rx.s_axis_rx_tuser;
                default: ;
            endcase
            if (rx.s_axis_rx_tlast) begin
                state_d = S_B0;
                beat_d  = '0;
            end
        end
    end

    always_comb begin
        push_flag = '0;
        push_flag[FLAG_LOOKUP] = 1'b1;
        push_flag[FLAG_TCP]    = is_tcp_d;
        push_flag[FLAG_PORT_MSB:FLAG_PORT_LSB] = PORT_ID;
    end

    assign pop = lkp.in_valid && lkp.in_ready;

    key_fifo #(
        .WIDTH (KEY_SIZE + 4),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clk     (clk156),
        .rst     (eth_rst),
        .wr_en   (push),
        .wr_data ({ip_src_d, ip_dst_d, sport_d, dport_d, push_flag}),
        .rd_en   (lkp.in_ready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign lkp.in_valid = !fifo_empty;
    assign {lkp.in_key, lkp.in_flag} = fifo_rd_data;

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            drop_cnt <= '0;
        end else if (push && fifo_full && !pop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

`ifdef KEY_EXTRACT_STATS_EN
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            pkt_cnt <= '0;
            key_cnt <= '0;
        end else begin
            if (beat_last) pkt_cnt <= pkt_cnt + 32'd1;
            if (push && (!fifo_full || pop)) key_cnt <= key_cnt + 32'd1;
        end
    end
`else
    logic unused_last;
    assign unused_last = beat_last;
`endif

endmodule

// File: tb/tb_eth_rx_key_extract.sv
// Directed self-checking bench for eth_rx_key_extract (PORT_ID 0 and 1 instances).
module tb_eth_rx_key_extract;

    logic clk156 = 1'b0;
    logic eth_rst;
    logic [15:0] drop_cnt0, drop_cnt1;
`ifdef KEY_EXTRACT_STATS_EN
    logic [31:0] pkt_cnt0, key_cnt0, pkt_cnt1, key_cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk156 = ~clk156;

    axis_rx_if rx ();
    key_lookup_if #(.KEY_SIZE(96)) lk0 ();
    key_lookup_if #(.KEY_SIZE(96)) lk1 ();

    eth_rx_key_extract #(.KEY_SIZE(96), .FIFO_DEPTH(4), .PORT_ID(2'd0)) dut0 (
        .clk156   (clk156),
        .eth_rst  (eth_rst),
        .rx       (rx),
        .lkp      (lk0),
        .drop_cnt (drop_cnt0)
`ifdef KEY_EXTRACT_STATS_EN
        , .pkt_cnt (pkt_cnt0), .key_cnt (key_cnt0)
`endif
    );

    eth_rx_key_extract #(.KEY_SIZE(96), .FIFO_DEPTH(4), .PORT_ID(2'd1)) dut1 (
        .clk156   (clk156),
        .eth_rst  (eth_rst),
        .rx       (rx),
        .lkp      (lk1),
        .drop_cnt (drop_cnt1)
`ifdef KEY_EXTRACT_STATS_EN
        , .pkt_cnt (pkt_cnt1), .key_cnt (key_cnt1)
`endif
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk156);
        #1;
    endtask

    // Drives one frame; returns 1 time unit after the edge that sampled the last beat.
    task automatic send_frame(input logic [15:0] et, input logic [7:0] vi, input logic [7:0] pr,
                              input logic [31:0] src, input logic [31:0] dst,
                              input logic [15:0] sp, input logic [15:0] dp,
                              input int nb, input bit usr, input bit rdy_last, input bit do_last);
        logic [7:0] b [64];
        bit last;
        for (int i = 0; i < 64; i++) b[i] = 8'(i + 8'h90);
        b[12] = et[15:8];   b[13] = et[7:0];   b[14] = vi;  b[23] = pr;
        b[26] = src[31:24]; b[27] = src[23:16]; b[28] = src[15:8]; b[29] = src[7:0];
        b[30] = dst[31:24]; b[31] = dst[23:16]; b[32] = dst[15:8]; b[33] = dst[7:0];
        b[34] = sp[15:8];   b[35] = sp[7:0];   b[36] = dp[15:8];  b[37] = dp[7:0];
        for (int n = 0; n < nb; n++) begin
            last = do_last && (n == nb - 1);
            rx.s_axis_rx_tvalid = 1'b1;
            for (int k = 0; k < 8; k++) rx.s_axis_rx_tdata[8*k +: 8] = b[8*n + k];
            rx.s_axis_rx_tkeep = 8'hFF;
            rx.s_axis_rx_tlast = last;
            rx.s_axis_rx_tuser = last ? usr : 1'b0;
            if (last && rdy_last) lk0.in_ready = 1'b1;
            tick();
            if (last && rdy_last) lk0.in_ready = 1'b0;
        end
        rx.s_axis_rx_tvalid = 1'b0;
        rx.s_axis_rx_tlast  = 1'b0;
        rx.s_axis_rx_tuser  = 1'b0;
    endtask

    function automatic logic [95:0] mk_key(input int i);
        return {32'h0a000010 + 32'(i), 32'h0b000020 + 32'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i)};
    endfunction

    task automatic send_idx(input int i, input bit rdy_last);
        send_frame(16'h0800, 8'h45, 8'd17, 32'h0a000010 + 32'(i), 32'h0b000020 + 32'(i),
                   16'h1000 + 16'(i), 16'h2000 + 16'(i), 6, 1'b1, rdy_last, 1'b1);
    endtask

    initial begin
        rx.s_axis_rx_tvalid = 1'b0;
        rx.s_axis_rx_tdata  = '0;
        rx.s_axis_rx_tkeep  = '0;
        rx.s_axis_rx_tlast  = 1'b0;
        rx.s_axis_rx_tuser  = 1'b0;
        lk0.in_ready = 1'b1;
        lk1.in_ready = 1'b1;
        eth_rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_valid", lk0.in_valid, 1'b0);
        check_eq("rst_key",   lk0.in_key, 96'h0);
        check_eq("rst_flag",  lk0.in_flag, 4'h0);
        check_eq("rst_drop",  drop_cnt0, 16'h0);
        eth_rst = 1'b0;
        tick();

        // UDP frame
        send_frame(16'h0800, 8'h45, 8'd17, 32'h0a000001, 32'h0a000002, 16'h1234, 16'h5678, 6, 1'b1, 1'b0, 1'b1);
        check_eq("udp_valid", lk0.in_valid, 1'b1);
        check_eq("udp_key",   lk0.in_key, 96'h0a000001_0a000002_1234_5678);
        check_eq("udp_flag",  lk0.in_flag, 4'b0001);
        check_eq("udp_flag_p1", lk1.in_flag, 4'b0101);
        tick();
        check_eq("udp_pulse", lk0.in_valid, 1'b0);

        // TCP frame
        send_frame(16'h0800, 8'h45, 8'd6, 32'hc0a80101, 32'hc0a80102, 16'h0050, 16'hc350, 6, 1'b1, 1'b0, 1'b1);
        check_eq("tcp_key",     lk0.in_key, 96'hc0a80101_c0a80102_0050_c350);
        check_eq("tcp_flag",    lk0.in_flag, 4'b0011);
        check_eq("tcp_flag_p1", lk1.in_flag, 4'b0111);
        tick();

        // Non-matching frames: ARP, IHL=6, ICMP, and bad tuser
        send_frame(16'h0806, 8'h45, 8'd17, 32'h1, 32'h2, 16'h3, 16'h4, 6, 1'b1, 1'b0, 1'b1);
        check_eq("arp_nokey", lk0.in_valid, 1'b0);
        check_eq("arp_drop",  drop_cnt0, 16'h0);
        send_frame(16'h0800, 8'h46, 8'd17, 32'h1, 32'h2, 16'h3, 16'h4, 6, 1'b1, 1'b0, 1'b1);
        check_eq("ihl6_nokey", lk0.in_valid, 1'b0);
        send_frame(16'h0800, 8'h45, 8'd1, 32'h1, 32'h2, 16'h3, 16'h4, 6, 1'b1, 1'b0, 1'b1);
        check_eq("icmp_nokey", lk0.in_valid, 1'b0);
        send_frame(16'h0800, 8'h45, 8'd17, 32'h1, 32'h2, 16'h3, 16'h4, 6, 1'b0, 1'b0, 1'b1);
        check_eq("bad_tuser_nokey", lk0.in_valid, 1'b0);
        check_eq("bad_tuser_drop",  drop_cnt0, 16'h0);

        // Runt, then a good frame
        send_frame(16'h0800, 8'h45, 8'd17, 32'h1, 32'h2, 16'h3, 16'h4, 3, 1'b1, 1'b0, 1'b1);
        check_eq("runt_nokey", lk0.in_valid, 1'b0);
        send_idx(1, 1'b0);
        check_eq("post_runt_key", lk0.in_key, mk_key(1));
        tick();

        // tlast on beat 4
        send_frame(16'h0800, 8'h45, 8'd17, 32'hac100001, 32'hac100002, 16'hbeef, 16'hcafe, 5, 1'b1, 1'b0, 1'b1);
        check_eq("b4_valid", lk0.in_valid, 1'b1);
        check_eq("b4_key",   lk0.in_key, 96'hac100001_ac100002_beef_cafe);
        tick();

        // Overflow: 6 frames into a 4-deep queue
        lk0.in_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_idx(i, 1'b0);
        check_eq("ovf_valid", lk0.in_valid, 1'b1);
        check_eq("ovf_drop",  drop_cnt0, 16'd2);
        repeat (3) tick();
        check_eq("stall_key", lk0.in_key, mk_key(0));
        lk0.in_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain_key%0d", i), lk0.in_key, mk_key(i));
            tick();
        end
        check_eq("drain_empty", lk0.in_valid, 1'b0);

        // Full queue, pop coincides with committing tlast
        lk0.in_ready = 1'b0;
        for (int i = 10; i < 14; i++) send_idx(i, 1'b0);
        send_idx(14, 1'b1);
        check_eq("fullpop_drop", drop_cnt0, 16'd2);
        check_eq("fullpop_head", lk0.in_key, mk_key(11));
        lk0.in_ready = 1'b1;
        for (int i = 11; i < 15; i++) begin
            check_eq($sformatf("fullpop_key%0d", i), lk0.in_key, mk_key(i));
            tick();
        end
        check_eq("fullpop_empty", lk0.in_valid, 1'b0);

        // Reset mid-header with a queued key and nonzero drop count
        lk0.in_ready = 1'b0;
        send_idx(20, 1'b0);
        send_frame(16'h0800, 8'h45, 8'd17, 32'h1, 32'h2, 16'h3, 16'h4, 3, 1'b1, 1'b0, 1'b0);
        eth_rst = 1'b1;
        tick();
        eth_rst = 1'b0;
        check_eq("mrst_valid", lk0.in_valid, 1'b0);
        check_eq("mrst_key",   lk0.in_key, 96'h0);
        check_eq("mrst_flag",  lk0.in_flag, 4'h0);
        check_eq("mrst_drop",  drop_cnt0, 16'h0);
        lk0.in_ready = 1'b1;
        send_idx(21, 1'b0);
        check_eq("mrst_next_valid", lk0.in_valid, 1'b1);
        check_eq("mrst_next_key",   lk0.in_key, mk_key(21));
        tick();

`ifdef KEY_EXTRACT_STATS_EN
        eth_rst = 1'b1;
        tick();
        eth_rst = 1'b0;
        send_frame(16'h0806, 8'h45, 8'd17, 32'h1, 32'h2, 16'h3, 16'h4, 6, 1'b1, 1'b0, 1'b1);
        send_idx(30, 1'b0);
        send_frame(16'h86dd, 8'h60, 8'd17, 32'h1, 32'h2, 16'h3, 16'h4, 6, 1'b1, 1'b0, 1'b1);
        send_idx(31, 1'b0);
        send_idx(32, 1'b0);
        tick();
        check_eq("stats_pkt", pkt_cnt0, 32'd5);
        check_eq("stats_key", key_cnt0, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
